// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch sequencer for the toy processor.
// Reads the external program counter, fetches the instruction at that
// address over a req/ack memory handshake, and latches it into IR.
// It then steers the counter (Load = jump, count = increment) and offers
// the instruction to decode over a valid/ready handshake.
// HALT parks the sequencer until Run drops; it is never issued to decode.

module instr_fetch #(
  parameter int          INSTR_W = 16,
  parameter int          ADDR_W  = 8,
  parameter logic [3:0]  OP_JZ   = 4'hD,
  parameter logic [3:0]  OP_JMP  = 4'hE,
  parameter logic [3:0]  OP_HALT = 4'hF
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Run,
  input  logic [ADDR_W-1:0]  PC,
  input  logic               Zero,
  output logic               Mem_req,
  output logic [ADDR_W-1:0]  Mem_addr,
  input  logic               Mem_ack,
  input  logic [INSTR_W-1:0] Mem_data,
  output logic [ADDR_W-1:0]  Count_in,
  output logic               Load,
  output logic               count,
  output logic [INSTR_W-1:0] Instr,
  output logic               Instr_valid,
  input  logic               Instr_ready,
  output logic               Halt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_HALTED
  } state_e;

  state_e             state_q;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               mem_req_q;
  logic               instr_valid_q;
  logic               halt_q;

  logic [3:0]         opcode;
  logic               is_halt;
  logic               take_jump;
  logic               load_d;
  logic               count_d;

  assign opcode = ir_q[INSTR_W-1 -: 4];

  // Decode the latched instruction; Zero is sampled live during DECODE, so
  // the counter strobes are combinational rather than registered.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    is_halt   = 1'b0;
    take_jump = 1'b0;
    load_d    = 1'b0;
    count_d   = 1'b0;
    if (opcode == OP_HALT) begin
      is_halt = 1'b1;
    end else if ((opcode == OP_JMP) || ((opcode == OP_JZ) && Zero)) begin
      take_jump = 1'b1;
    end
    if (state_q == S_DECODE) begin
      load_d  = take_jump;
      count_d = !is_halt && !take_jump;
    end
  end

  // Sequencer state and registered handshake outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      // NOTE: IR is a single architectural register, not a memory array; it
      // is reset because Instr and Count_in are visible straight out of it.
      state_q       <= S_IDLE;
      ir_q          <= '0;
      mem_addr_q    <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values and the update order inside this block is irrelevant.
      case (state_q)
        S_IDLE: begin
          if (Run) begin
            state_q    <= S_FETCH;
            mem_addr_q <= PC;
            mem_req_q  <= 1'b1;
          end
        end

        S_FETCH: begin
          // Run is deliberately ignored here: a started fetch completes.
          if (Mem_ack) begin
            ir_q      <= Mem_data;
            mem_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (is_halt) begin
            halt_q  <= 1'b1;
            state_q <= S_HALTED;
          end else begin
            instr_valid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (Instr_ready) begin
            instr_valid_q <= 1'b0;
            if (Run) begin
              // The counter already moved at the end of DECODE, so PC here
              // is the address of the next instruction.
              state_q    <= S_FETCH;
              mem_addr_q <= PC;
              mem_req_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        S_HALTED: begin
          // Leaving HALTED needs Run low first, so a held Run cannot refetch
          // the HALT in a tight loop.
          if (!Run) begin
            halt_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q       <= S_IDLE;
          mem_req_q     <= 1'b0;
          instr_valid_q <= 1'b0;
          halt_q        <= 1'b0;
        end
      endcase
    end
  end

  assign Mem_req     = mem_req_q;
  assign Mem_addr    = mem_addr_q;
  assign Count_in    = ir_q[ADDR_W-1:0];
  assign Load        = load_d;
  assign count       = count_d;
  assign Instr       = ir_q;
  assign Instr_valid = instr_valid_q;
  assign Halt        = halt_q;

endmodule
